// File: rtl/minihls_exec.sv
// minihls_exec: small micro-programmed register machine with start/finish handshake.
// Loadable program memory, NREGS signed registers, watchdog on instruction count.
module minihls_exec #(
    parameter int WIDTH      = 32,
    parameter int NREGS      = 4,
    parameter int PDEPTH     = 16,
    parameter int IMM_W      = 16,
    parameter int MAX_CYCLES = 256,
    localparam int RIDX_W    = $clog2(NREGS),
    localparam int PC_W      = $clog2(PDEPTH),
    localparam int INSTR_W   = 3 + 3 * RIDX_W + IMM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               ready,
    input  logic               accept,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH-1:0]   out,
    output logic               err
);
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MOV  = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_BNZ  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    logic [INSTR_W-1:0] mem_q [PDEPTH];
    logic               mem_we;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic [INSTR_W-1:0]      instr;
    logic [2:0]              op;
    logic [RIDX_W-1:0]       rd, rs1, rs2;
    logic signed [IMM_W-1:0] imm;
    logic [WIDTH-1:0]        a, b, sext;

    assign instr = mem_q[pc_q];
    assign op    = instr[INSTR_W-1 -: 3];
    assign rd    = instr[IMM_W + 2 * RIDX_W +: RIDX_W];
    assign rs1   = instr[IMM_W + RIDX_W +: RIDX_W];
    assign rs2   = instr[IMM_W +: RIDX_W];
    assign imm   = instr[IMM_W-1:0];
    assign a     = regs_q[rs1];
    assign b     = regs_q[rs2];
    assign sext  = WIDTH'(imm);

    logic             finish, jump;
    logic [WIDTH-1:0] fin_val;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = err_q;
        regs_d  = regs_q;
        mem_we  = 1'b0;
        finish  = 1'b0;
        jump    = 1'b0;
        fin_val = '0;
        case (state_q)
            S_IDLE: begin
                if (prog_we) begin
                    mem_we = 1'b1;
                end else if (ready) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    regs_d  = '{default: '0};
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                case (op)
                    OP_LDI:  regs_d[rd] = sext;
                    OP_ADD:  regs_d[rd] = a + b;
                    OP_SUB:  regs_d[rd] = a - b;
                    OP_MOV:  regs_d[rd] = a;
                    OP_OUT:  begin finish = 1'b1; fin_val = a; end
                    OP_BNZ:  jump = (a != '0);
                    OP_HALT: begin finish = 1'b1; fin_val = regs_q[0]; end
                    default: ;
                endcase
                // Last slot without a taken branch: the instruction still
                // executes, then the run ends with the updated r0.
                if (!finish && !jump && pc_q == PC_W'(PDEPTH - 1)) begin
                    finish  = 1'b1;
                    fin_val = regs_d[0];
                end
                if (finish) begin
                    state_d = S_DONE;
                    out_d   = fin_val;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = S_DONE;
                    out_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    pc_d = jump ? imm[PC_W-1:0] : pc_q + PC_W'(1);
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign valid = (state_q == S_DONE);
    assign out   = out_q;
    assign err   = err_q;
endmodule

// File: tb/tb_minihls_exec.sv
// Bench for minihls_exec: directed table, handshake/reset sequences and
// random programs checked against an instruction-level interpreter.
module tb_minihls_exec;
    typedef logic [24:0] prog_t [16];

    typedef struct {
        string       name;
        int          pid;
        logic [15:0] eo;
        bit          ee;
        int          ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [24:0] prog_data = '0;
    logic        ready = 1'b0;
    logic        accept = 1'b0;
    logic        busy, valid, err;
    logic [15:0] out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    minihls_exec #(
        .WIDTH(16), .NREGS(4), .PDEPTH(16), .IMM_W(16), .MAX_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .ready(ready), .accept(accept),
        .busy(busy), .valid(valid), .out(out), .err(err)
    );

    function automatic logic [24:0] I(input int op, input int rd,
                                      input int rs1, input int rs2, input int imm);
        return {op[2:0], rd[1:0], rs1[1:0], rs2[1:0], imm[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Interpreter: step through the program, stop on OUT/HALT, on running
    // past the last slot, or after 64 executed instructions.
    task automatic model(input prog_t p, output logic [15:0] o,
                         output bit e, output int c);
        logic [15:0] r [4];
        logic [24:0] w;
        int pc, npc, op, rd;
        logic [15:0] va, vb, im;
        bit fin;
        r = '{default: '0};
        pc = 0; o = '0; e = 1'b1; c = 64;
        for (int s = 1; s <= 64; s++) begin
            w = p[pc];
            op = int'(w[24:22]); rd = int'(w[21:20]);
            va = r[w[19:18]]; vb = r[w[17:16]]; im = w[15:0];
            npc = pc + 1; fin = 1'b0;
            case (op)
                1: r[rd] = im;
                2: r[rd] = va + vb;
                3: r[rd] = va - vb;
                4: r[rd] = va;
                5: begin o = va; fin = 1'b1; end
                6: if (va != 0) npc = int'(im[3:0]);
                7: begin o = r[0]; fin = 1'b1; end
                default: ;
            endcase
            if (!fin && npc == 16) begin o = r[0]; fin = 1'b1; end
            if (fin) begin e = 1'b0; c = s; return; end
            pc = npc;
        end
        o = '0;
    endtask

    task automatic load(input prog_t p);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = p[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_run(input string nm, input logic [15:0] eo, input bit ee,
                          input int ec, input int hold, input bit poke);
        int cyc;
        bit done;
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        cyc = 0; done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            if (valid) done = 1'b1;
            else begin
                if (busy) cyc++;
                if (poke && t == 2) begin
                    ready = 1'b1; accept = 1'b1;
                    prog_we = 1'b1; prog_addr = 4'd1; prog_data = I(7, 0, 0, 0, 0);
                end
                if (poke && t == 4) begin
                    ready = 1'b0; accept = 1'b0; prog_we = 1'b0;
                end
                @(negedge clk);
            end
        end
        ready = 1'b0; accept = 1'b0; prog_we = 1'b0;
        if (!done) begin
            chk({nm, "/timeout"}, 32'(valid), 32'd1);
            return;
        end
        chk({nm, "/out"}, 32'(out), 32'(eo));
        chk({nm, "/err"}, 32'(err), 32'(ee));
        chk({nm, "/cycles"}, 32'(cyc), 32'(ec));
        for (int h = 0; h < hold; h++) begin
            if (h == 3) ready = 1'b1;
            if (h == 5) ready = 1'b0;
            @(negedge clk);
            chk({nm, "/hold_valid"}, 32'(valid), 32'd1);
            chk({nm, "/hold_out"}, 32'(out), 32'(eo));
            chk({nm, "/hold_err"}, 32'(err), 32'(ee));
        end
        ready = 1'b0;
        accept = 1'b1;
        @(negedge clk) accept = 1'b0;
        chk({nm, "/valid_drop"}, 32'(valid), 32'd0);
        chk({nm, "/err_drop"}, 32'(err), 32'd0);
        chk({nm, "/no_restart"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    prog_t progs [7];
    vec_t  vt [7];
    prog_t rp;
    logic [15:0] mo;
    bit me;
    int mc, op;

    initial begin
        for (int k = 0; k < 7; k++) progs[k] = '{default: '0};
        progs[0][0:4] = '{I(1,0,0,0,3), I(1,1,0,0,8), I(1,2,0,0,11),
                          I(1,0,0,0,7), I(5,0,0,0,0)};
        progs[1][0:6] = '{I(1,0,0,0,5), I(1,1,0,0,1), I(1,2,0,0,0),
                          I(2,2,2,0,0), I(3,0,0,1,0), I(6,0,0,0,3), I(5,0,2,0,0)};
        progs[2][0:1] = '{I(1,0,0,0,1), I(6,0,0,0,1)};
        progs[3][0] = I(1,0,0,0,16'h7FFF);
        for (int i = 1; i < 16; i++) progs[3][i] = I(2,0,0,0,0);
        progs[4][0:4] = '{I(1,0,0,0,16'hFFFD), I(1,1,0,0,5), I(3,2,0,1,0),
                          I(4,3,2,0,0), I(5,0,3,0,0)};
        progs[5][0:1] = '{I(1,0,0,0,9), I(7,0,0,0,0)};

        vt[0] = '{"straight", 0, 16'd7,     1'b0, 5};
        vt[1] = '{"loop",     1, 16'd15,    1'b0, 19};
        vt[2] = '{"watchdog", 2, 16'd0,     1'b1, 64};
        vt[3] = '{"falloff",  3, 16'h8000,  1'b0, 16};
        vt[4] = '{"negsub",   4, 16'hFFF8,  1'b0, 5};
        vt[5] = '{"halt",     5, 16'd9,     1'b0, 2};
        vt[6] = '{"allnop",   6, 16'd0,     1'b0, 16};

        repeat (2) @(negedge clk);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/valid", 32'(valid), 32'd0);
        chk("reset/out", 32'(out), 32'd0);
        chk("reset/err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            load(progs[vt[k].pid]);
            do_run(vt[k].name, vt[k].eo, vt[k].ee, vt[k].ec,
                   (k == 0) ? 10 : 0, (k == 1 || k == 3));
            if (k == 3)
                do_run("falloff_rerun", vt[k].eo, vt[k].ee, vt[k].ec, 0, 1'b0);
        end

        // Reset mid-RUN, then restart without reloading.
        load(progs[1]);
        do_run("loop_pre", 16'd15, 1'b0, 19, 0, 1'b0);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun/busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrun/busy", 32'(busy), 32'd0);
        chk("midrun/valid", 32'(valid), 32'd0);
        chk("midrun/out", 32'(out), 32'd0);
        @(negedge clk) rst = 1'b1;
        do_run("midrun_restart", 16'd15, 1'b0, 19, 0, 1'b0);

        // Reset mid-DONE.
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        repeat (25) @(negedge clk);
        chk("middone/valid_before", 32'(valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("middone/valid", 32'(valid), 32'd0);
        chk("middone/out", 32'(out), 32'd0);
        @(negedge clk) rst = 1'b1;
        do_run("middone_restart", 16'd15, 1'b0, 19, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 16; i++) begin
                op = $urandom_range(0, 7);
                if ((op == 5 || op == 7) && $urandom_range(0, 3) != 0) op = 2;
                rp[i] = I(op, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3),
                          (op == 6) ? $urandom_range(0, 15) : $urandom_range(0, 65535));
            end
            model(rp, mo, me, mc);
            load(rp);
            do_run("random", mo, me, mc, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
